// File: rtl/key_debounce_if.sv
// Push-button conditioner signal bundle: raw button in, debounced level and events out.
interface key_debounce_if #(
  parameter int unsigned CNT_W = 8
);
  logic             button_in;
  logic             key_level;
  logic             key_press;
  logic             key_release;
  logic             long_press;
  logic [CNT_W-1:0] press_cnt;

  modport master (
    input  button_in,
    output key_level, key_press, key_release, long_press, press_cnt
  );

  modport slave (
    output button_in,
    input  key_level, key_press, key_release, long_press, press_cnt
  );
endinterface

// File: rtl/key_debounce.sv
// Debouncer for an active-low bouncy button: 2-FF synchroniser, filter FSM, press/release
// pulses, stable level and wrapping press counter. Define LONG_PRESS_EN for long_press.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned LONG_CYCLES     = 50_000_000,
  parameter int unsigned CNT_W           = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  key_debounce_if.master bus
);

  localparam int unsigned DCNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FILTER_DN = 2'd1,
    HELD      = 2'd2,
    FILTER_UP = 2'd3
  } state_e;

  logic [1:0]        sync_q, sync_d;
  logic              btn_s;
  state_e            state_q, state_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic              key_level_q, key_level_d;
  logic              key_press_q, key_press_d;
  logic              key_release_q, key_release_d;
  logic [CNT_W-1:0]  press_cnt_q, press_cnt_d;

  // Shift the raw input in; bit 1 is the clean synchronised level (1 = released).
  always_comb begin
    sync_d = {sync_q[0], bus.button_in};
  end
  assign btn_s = sync_q[1];

  // Debounce FSM: any change of btn_s during a filter window aborts it.
  always_comb begin
    state_d       = state_q;
    dcnt_d        = dcnt_q;
    key_level_d   = key_level_q;
    key_press_d   = 1'b0;
    key_release_d = 1'b0;
    press_cnt_d   = press_cnt_q;
    case (state_q)
      IDLE: begin
        if (!btn_s) begin
          state_d = FILTER_DN;
          dcnt_d  = '0;
        end
      end
      FILTER_DN: begin
        if (btn_s) begin
          state_d = IDLE;
        end else if (dcnt_q == DCNT_LAST) begin
          state_d     = HELD;
          key_press_d = 1'b1;
          key_level_d = 1'b1;
          press_cnt_d = press_cnt_q + CNT_W'(1);
        end else begin
          dcnt_d = dcnt_q + DCNT_W'(1);
        end
      end
      HELD: begin
        if (btn_s) begin
          state_d = FILTER_UP;
          dcnt_d  = '0;
        end
      end
      FILTER_UP: begin
        if (!btn_s) begin
          state_d = HELD;
        end else if (dcnt_q == DCNT_LAST) begin
          state_d       = IDLE;
          key_release_d = 1'b1;
          key_level_d   = 1'b0;
        end else begin
          dcnt_d = dcnt_q + DCNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q        <= 2'b11;
      state_q       <= IDLE;
      dcnt_q        <= '0;
      key_level_q   <= 1'b0;
      key_press_q   <= 1'b0;
      key_release_q <= 1'b0;
      press_cnt_q   <= '0;
    end else begin
      sync_q        <= sync_d;
      state_q       <= state_d;
      dcnt_q        <= dcnt_d;
      key_level_q   <= key_level_d;
      key_press_q   <= key_press_d;
      key_release_q <= key_release_d;
      press_cnt_q   <= press_cnt_d;
    end
  end

  assign bus.key_level   = key_level_q;
  assign bus.key_press   = key_press_q;
  assign bus.key_release = key_release_q;
  assign bus.press_cnt   = press_cnt_q;

`ifdef LONG_PRESS_EN
  localparam int unsigned HOLD_W = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              long_done_q, long_done_d;
  logic              long_press_q, long_press_d;

  // Hold timer keeps running through release bounces; long_done_q limits it to one pulse.
  always_comb begin
    hold_cnt_d   = hold_cnt_q;
    long_done_d  = long_done_q;
    long_press_d = 1'b0;
    if (key_press_d) begin
      hold_cnt_d  = '0;
      long_done_d = 1'b0;
    end else if ((state_q == HELD || state_q == FILTER_UP) && !long_done_q) begin
      if (hold_cnt_q == HOLD_LAST) begin
        long_press_d = 1'b1;
        long_done_d  = 1'b1;
      end else begin
        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q   <= '0;
      long_done_q  <= 1'b0;
      long_press_q <= 1'b0;
    end else begin
      hold_cnt_q   <= hold_cnt_d;
      long_done_q  <= long_done_d;
      long_press_q <= long_press_d;
    end
  end

  assign bus.long_press = long_press_q;
`else
  logic unused_long_cycles;
  assign unused_long_cycles = ^LONG_CYCLES;
  assign bus.long_press     = 1'b0;
`endif

endmodule
